// File: rtl/aes_pkg.sv
// Shared AES constants, key-schedule state encoding and small word helpers.
package aes_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GEN  = 2'd1,
        ST_DONE = 2'd2
    } keyexp_state_e;

    // Key length in 32-bit words (Nk) and the matching round count (Nr)
    localparam logic [3:0] NK_128 = 4'd4;
    localparam logic [3:0] NK_192 = 4'd6;
    localparam logic [3:0] NK_256 = 4'd8;
    localparam logic [3:0] NR_128 = 4'd10;
    localparam logic [3:0] NR_192 = 4'd12;
    localparam logic [3:0] NR_256 = 4'd14;

    localparam logic [7:0] RCON_INIT = 8'h01;

    // Multiply by x in GF(2^8) modulo the AES polynomial 0x11b
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Cyclic left rotation of a word by one byte
    function automatic logic [31:0] rotWord(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    // Only the three AES key lengths are accepted
    function automatic logic isValidNk(input logic [3:0] nk);
        return (nk == NK_128) || (nk == NK_192) || (nk == NK_256);
    endfunction

    // Round count belonging to a (valid) key length
    function automatic logic [3:0] nrFromNk(input logic [3:0] nk);
        logic [3:0] nr;
        case (nk)
            NK_128:  nr = NR_128;
            NK_192:  nr = NR_192;
            NK_256:  nr = NR_256;
            default: nr = 4'd0;
        endcase
        return nr;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box; one byte in, one byte out.
// The same cell is reused by the encrypt datapath.
module aes_sbox (
    input  logic [7:0] data_i,
    output logic [7:0] data_o
);

    // Entry 0 sits in the top byte, so entry x starts at bit (255-x)*8
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Table lookup; (255-x)*8 is simply {~x, 3'b000}
    always_comb begin
        data_o = SBOX_TABLE[{~data_i, 3'b000} +: 8];
    end

endmodule

// File: rtl/aes_key_expansion.sv
// AES key schedule generator: expands a 128/192/256-bit key one word per
// cycle and writes each finished 128-bit round key into the round-key RAM.
module aes_key_expansion
    import aes_pkg::*;
(
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iKey_load,
    input  logic [3:0]  iSize,
    input  logic [31:0] iKey_1,
    input  logic [31:0] iKey_2,
    input  logic [31:0] iKey_3,
    input  logic [31:0] iKey_4,
    input  logic [31:0] iKey_5,
    input  logic [31:0] iKey_6,
    input  logic [31:0] iKey_7,
    input  logic [31:0] iKey_8,
    output logic        oBusy,
    output logic        oDone,
    output logic        oKey_valid,
    output logic [3:0]  oRound,
    output logic        oRAM_wr,
    output logic [3:0]  oRAM_addr,
    output logic [31:0] oRAM_data_1,
    output logic [31:0] oRAM_data_2,
    output logic [31:0] oRAM_data_3,
    output logic [31:0] oRAM_data_4
);

    keyexp_state_e state_q, state_d;

    logic [3:0]  nk_q, nk_d;
    logic [3:0]  nr_q, nr_d;
    logic [5:0]  idx_q, idx_d;
    logic [2:0]  modCnt_q, modCnt_d;
    logic [7:0]  rcon_q, rcon_d;
    logic [31:0] window_q [8];
    logic [31:0] window_d [8];
    logic [31:0] stage_q [3];
    logic [31:0] stage_d [3];

    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        keyValid_q, keyValid_d;
    logic        ramWr_q, ramWr_d;
    logic [3:0]  ramAddr_q, ramAddr_d;
    logic [31:0] ramData_q [4];
    logic [31:0] ramData_d [4];

    logic [31:0] keyWords [8];
    logic [3:0]  loadBase;
    logic [31:0] prevWord;
    logic [31:0] backWord;
    logic [31:0] sboxIn;
    logic [31:0] sboxOut;
    logic [31:0] newWord;
    logic        keyPhase;
    logic        rotPhase;
    logic        subPhase;
    logic        lastWord;
    logic        modWrap;

    assign keyWords[0] = iKey_1;
    assign keyWords[1] = iKey_2;
    assign keyWords[2] = iKey_3;
    assign keyWords[3] = iKey_4;
    assign keyWords[4] = iKey_5;
    assign keyWords[5] = iKey_6;
    assign keyWords[6] = iKey_7;
    assign keyWords[7] = iKey_8;

    // window_q[m] holds w[i-8+m]: the key is preloaded Nk words back so the
    // first Nk cycles simply shift the key words out as w[0..Nk-1]
    always_comb begin
        loadBase = 4'd8 - iSize;
        prevWord = window_q[7];
        backWord = window_q[3'(4'd8 - nk_q)];
        keyPhase = (idx_q < {2'b00, nk_q});
        rotPhase = !keyPhase && (modCnt_q == 3'd0);
        subPhase = !keyPhase && (nk_q == NK_256) && (modCnt_q == 3'd4);
        lastWord = (idx_q == {nr_q, 2'b11});
        modWrap  = ({1'b0, modCnt_q} == (nk_q - 4'd1));
        sboxIn   = rotPhase ? rotWord(prevWord) : prevWord;
    end

    // SubWord: four parallel byte substitutions
    for (genvar b = 0; b < 4; b++) begin : g_subword
        aes_sbox u_sbox (
            .data_i (sboxIn[8*b +: 8]),
            .data_o (sboxOut[8*b +: 8])
        );
    end

    // Next schedule word w[i] from the history window
    always_comb begin
        newWord = backWord ^ prevWord;
        if (keyPhase) begin
            newWord = backWord;
        end else if (rotPhase) begin
            newWord = backWord ^ sboxOut ^ {rcon_q, 24'h000000};
        end else if (subPhase) begin
            newWord = backWord ^ sboxOut;
        end
    end

    // Next-state and registered-output logic of the IDLE/GEN/DONE sequencer
    always_comb begin
        state_d    = state_q;
        nk_d       = nk_q;
        nr_d       = nr_q;
        idx_d      = idx_q;
        modCnt_d   = modCnt_q;
        rcon_d     = rcon_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        keyValid_d = keyValid_q;
        ramWr_d    = 1'b0;
        ramAddr_d  = ramAddr_q;
        for (int m = 0; m < 8; m++) begin
            window_d[m] = window_q[m];
        end
        for (int m = 0; m < 3; m++) begin
            stage_d[m] = stage_q[m];
        end
        for (int m = 0; m < 4; m++) begin
            ramData_d[m] = ramData_q[m];
        end

        case (state_q)
            ST_IDLE: begin
                if (iKey_load && isValidNk(iSize)) begin
                    state_d    = ST_GEN;
                    nk_d       = iSize;
                    nr_d       = nrFromNk(iSize);
                    idx_d      = 6'd0;
                    modCnt_d   = 3'd0;
                    rcon_d     = RCON_INIT;
                    busy_d     = 1'b1;
                    keyValid_d = 1'b0;
                    for (int m = 0; m < 8; m++) begin
                        if (4'(m) >= loadBase) begin
                            window_d[m] = keyWords[3'(4'(m) - loadBase)];
                        end else begin
                            window_d[m] = 32'h0;
                        end
                    end
                end
            end

            ST_GEN: begin
                for (int m = 0; m < 7; m++) begin
                    window_d[m] = window_q[m+1];
                end
                window_d[7] = newWord;
                idx_d       = idx_q + 6'd1;
                modCnt_d    = modWrap ? 3'd0 : modCnt_q + 3'd1;
                if (rotPhase) begin
                    rcon_d = xtime(rcon_q);
                end
                case (idx_q[1:0])
                    2'd0: stage_d[0] = newWord;
                    2'd1: stage_d[1] = newWord;
                    2'd2: stage_d[2] = newWord;
                    default: begin
                        ramWr_d      = 1'b1;
                        ramAddr_d    = idx_q[5:2];
                        ramData_d[0] = stage_q[0];
                        ramData_d[1] = stage_q[1];
                        ramData_d[2] = stage_q[2];
                        ramData_d[3] = newWord;
                    end
                endcase
                if (lastWord) begin
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                state_d    = ST_IDLE;
                done_d     = 1'b1;
                keyValid_d = 1'b1;
                busy_d     = 1'b0;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; synchronous reset abandons any expansion
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q    <= ST_IDLE;
            nk_q       <= 4'd0;
            nr_q       <= 4'd0;
            idx_q      <= 6'd0;
            modCnt_q   <= 3'd0;
            rcon_q     <= RCON_INIT;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            keyValid_q <= 1'b0;
            ramWr_q    <= 1'b0;
            ramAddr_q  <= 4'd0;
            for (int m = 0; m < 8; m++) begin
                window_q[m] <= 32'h0;
            end
            for (int m = 0; m < 3; m++) begin
                stage_q[m] <= 32'h0;
            end
            for (int m = 0; m < 4; m++) begin
                ramData_q[m] <= 32'h0;
            end
        end else begin
            state_q    <= state_d;
            nk_q       <= nk_d;
            nr_q       <= nr_d;
            idx_q      <= idx_d;
            modCnt_q   <= modCnt_d;
            rcon_q     <= rcon_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            keyValid_q <= keyValid_d;
            ramWr_q    <= ramWr_d;
            ramAddr_q  <= ramAddr_d;
            for (int m = 0; m < 8; m++) begin
                window_q[m] <= window_d[m];
            end
            for (int m = 0; m < 3; m++) begin
                stage_q[m] <= stage_d[m];
            end
            for (int m = 0; m < 4; m++) begin
                ramData_q[m] <= ramData_d[m];
            end
        end
    end

    assign oBusy       = busy_q;
    assign oDone       = done_q;
    assign oKey_valid  = keyValid_q;
    assign oRound      = nr_q;
    assign oRAM_wr     = ramWr_q;
    assign oRAM_addr   = ramAddr_q;
    assign oRAM_data_1 = ramData_q[0];
    assign oRAM_data_2 = ramData_q[1];
    assign oRAM_data_3 = ramData_q[2];
    assign oRAM_data_4 = ramData_q[3];

endmodule

// File: doc/aes_key_expansion.md
# aes_key_expansion

Round-key generator and writer for the AES round-key RAM. It accepts a 128/192/256-bit cipher key and runs the FIPS-197 key schedule one 32-bit word per cycle. Each completed 128-bit round key is written into the RAM that the AES encrypt/decrypt datapath reads through its 4-bit address and four 32-bit data lanes. It sits between the CPU/Avalon key registers and that RAM, and must finish before the datapath's parameters are loaded.

## Interface
Parameters:
- none (key sizes fixed by AES; constants in `aes_pkg`)

Ports:
- iClk  in  1  system clock
- iRst  in  1  reset; one clock; reset is synchronous and active-high
- iKey_load  in  1  single-cycle request to start expansion
- iSize  in  4  Nk = 4, 6 or 8 (key words); other values are invalid
- iKey_1..iKey_8  in  32 each  key words w[0]..w[7]; bits [31:24] hold the first key byte; unused words are ignored
- oBusy  out  1  expansion in progress
- oDone  out  1  one-cycle pulse after the final RAM write
- oKey_valid  out  1  RAM holds a complete schedule for the last accepted key
- oRound  out  4  Nr = Nk+6 of the last accepted key (10/12/14)
- oRAM_wr  out  1  write strobe
- oRAM_addr  out  4  round-key index 0..Nr
- oRAM_data_1..oRAM_data_4  out  32 each  round-key words w[4k]..w[4k+3]

## Operation
- States: IDLE, GEN, DONE.
- IDLE -> GEN when iKey_load=1 and iSize is 4, 6 or 8. On that edge the block:
  - latches Nk and Nr;
  - loads the 8-word history window from iKey;
  - clears word index i to 0 and sets Rcon to 0x01;
  - clears oKey_valid and sets oBusy.
- In IDLE, a load with an invalid iSize is ignored: no state change, and oKey_valid is unchanged.
- In GEN or DONE, iKey_load is ignored.
- GEN produces one word w[i] per cycle:
  - i < Nk: w[i] = key word i.
  - i mod Nk == 0: w[i] = w[i-Nk] ^ SubWord(RotWord(w[i-1])) ^ {Rcon,24'h0}, then Rcon <= xtime(Rcon). Sequence: 01,02,04,08,10,20,40,80,1B,36.
  - Nk==8 and i mod 8 == 4: w[i] = w[i-8] ^ SubWord(w[i-1]).
  - otherwise: w[i] = w[i-Nk] ^ w[i-1].
- i mod Nk is tracked with a wrapping counter, not a divider.
- Output words accumulate into a 4-word staging register. When i[1:0]==3, the next cycle drives oRAM_wr=1 with oRAM_addr=i>>2 and the staged words (data_1 = w[4k]).
- GEN -> DONE after i = 4·Nr+3. DONE lasts one cycle: oDone=1, oKey_valid<=1, oBusy<=0. DONE -> IDLE.
- The schedule is always stored in forward order (address k = round k), regardless of encrypt or decrypt. The datapath handles reverse reading for decryption.
- Reset at any time, including mid-GEN:
  - state IDLE; all outputs 0; Rcon 0x01; i=0.
  - no further writes occur, and partially written RAM is treated as invalid (oKey_valid=0).
- Output values after reset: oBusy=0, oDone=0, oKey_valid=0, oRound=0, oRAM_wr=0, oRAM_addr=0, oRAM_data_*=0.

## Timing
- Cycle 0 is the first cycle after the edge that accepts iKey_load; word i is computed in cycle i.
- All outputs are registered.
- oRAM_wr is high exactly in cycles 4k+4 for k = 0..Nr, with no gaps between writes other than the intervening 3 cycles.
- Last write is in cycle 4·Nr+4: 44, 52 or 60 for Nk = 4, 6, 8.
- oDone and the rising edge of oKey_valid occur in cycle 4·Nr+5. oBusy falls in the same cycle.
- A new iKey_load is accepted in cycle 4·Nr+6 at the earliest.
- Critical path: 4 S-box lookups, then XOR, then register. There is no multi-cycle path.

## Structure
- `aes_pkg`:
  - state enum;
  - NK_128/192/256 and matching NR constants;
  - RCON_INIT;
  - xtime function;
  - RotWord function.
- Sub-module `aes_sbox`: combinational 8-bit forward S-box, instantiated 4× for SubWord. It is shared with the encrypt path.
- Top level contains the FSM, index/mod counters, 8×32 history window, Rcon register and staging register.

## Test plan
- 128-bit key 2b7e1516 28aed2a6 abf71588 09cf4f3c:
  - 11 writes, addr 0..10;
  - addr 1 data_1 = a0fafe17;
  - addr 10 = d014f9a8 c9ee2589 e13f0cc8 b6630ca6;
  - oDone in cycle 45.
- 192-bit key 8e73b0f7 da0e6452 c810f32b 809079e5 62f8ead2 522c6b7b:
  - addr 1 data_3 (w[6]) = fe0c91f7;
  - addr 12 = e98ba06f 448c773c 8ecc7204 01002202;
  - oRound = 12.
- 256-bit key 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4:
  - addr 2 data_1 (w[8]) = 9ba35411;
  - addr 14 = fe4890d1 e6188d0b 046df344 706c631e;
  - last write in cycle 60.
- iKey_load pulsed again in cycle 20 of a 128-bit run: ignored; written data identical to the first scenario.
- iRst asserted in cycle 17 of a 256-bit run: no oRAM_wr afterwards, oKey_valid=0, all outputs 0. A rerun then gives the third scenario's results.
- iKey_load with iSize=5: no oBusy, no writes, and oKey_valid keeps its prior value.
